execute_stage: RTL
==================

Name: execute_stage

Overview:
- Y86-64 execute stage. Sits directly downstream of the decode/writeback block and upstream of the memory stage.
- Consumes decoded operands (icode, ifun, rA, rB, valA, valB, valC). Computes valE and updates the condition codes (ZF, SF, OF).
- Evaluates the branch/cmov condition (cnd) and resolves the write-back destination dstE.
- Output goes to a single-entry registered buffer with a valid/ready handshake. A halt state machine freezes the stage on halt or on an illegal instruction.

Parameters:
- DATA_W, 64, operand and result width.
- STACK_STEP, 8, value subtracted from or added to %rsp by call, ret, pushq and popq.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clock  in  1  system clock; all state updates on the posedge.
- resetn  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode presents a valid instruction.
- dec_ready  out  1  stage can accept an instruction this cycle.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A id.
- rB  in  4  register B id.
- valA  in  DATA_W  operand A.
- valB  in  DATA_W  operand B.
- valC  in  DATA_W  immediate/displacement.
- ex_valid  out  1  output buffer holds a result.
- ex_ready  in  1  downstream accepts the result.
- ex_icode  out  4  registered icode.
- ex_valE  out  DATA_W  ALU result.
- ex_valA  out  DATA_W  valA passed through.
- ex_dstE  out  4  destination for valE; 4'hF means none.
- ex_dstM  out  4  destination for valM: rA for icode 5 and B, else 4'hF.
- ex_cnd  out  1  condition result.
- cc  out  3  current {ZF,SF,OF}.
- stat  out  2  0=AOK, 1=HLT, 2=INS; registered with the result.

Behaviour:
- Clocking and reset: single clock domain; all registers update on the clock posedge.
- resetn low (asynchronous):
  - ex_valid=0, cc=CC_RESET, state=RUN, stat=0.
  - All ex_* data outputs are 0 and ex_dstE/ex_dstM are 4'hF.
  - An in-flight result is discarded.
- Ready and accept:
  - dec_ready = (state==RUN) && (!ex_valid || ex_ready). This is combinational, so a full buffer still accepts in the same cycle it drains.
  - accept = dec_valid && dec_ready.
  - On accept, all ex_* fields load at that edge and ex_valid=1. Latency is 1 cycle.
  - If ex_valid && ex_ready && !accept, then ex_valid goes to 0.
  - While ex_valid && !ex_ready, the outputs hold stable.
- ALU, by icode (DATA_W wrap-around arithmetic, no saturation):
  - 0 and 1: valE=0.
  - 2 and 3: valE=valA and valC respectively.
  - 4 and 5: valE=valB+valC.
  - 6, by ifun: 0 valB+valA; 1 valB-valA; 2 valB&valA; 3 valB^valA.
  - 7: valE=0.
  - 8 and A: valE=valB-STACK_STEP.
  - 9 and B: valE=valB+STACK_STEP.
- Condition codes:
  - Updated only on accepting icode 6 with ifun 0-3.
  - ZF=(valE==0); SF=valE[DATA_W-1].
  - OF for add: sign(valA)==sign(valB) && sign(valE)!=sign(valB).
  - OF for sub: sign(valA)!=sign(valB) && sign(valE)!=sign(valB).
  - OF for and/xor: 0.
- cnd:
  - For icode 2 and 7, cnd is computed from the cc value held before this instruction (the register value, not a bypass). Any other icode gives cnd=1.
  - ifun mapping: 0 gives 1; 1 gives (SF^OF)|ZF; 2 gives SF^OF; 3 gives ZF; 4 gives !ZF; 5 gives !(SF^OF); 6 gives !(SF^OF)&!ZF.
- dstE:
  - icode 2 gives rB if cnd, else 4'hF.
  - icode 3 and 6 give rB.
  - icode 8, 9, A, B give 4'h4.
  - All others give 4'hF.
- Illegal instructions: icode>4'hB, ifun>3 on icode 6, or ifun>6 on icode 2 or 7. Each gives stat=2 with dstE=dstM=4'hF and no cc update.
- Halt state machine (RUN, HALTED):
  - Accepting icode 0 gives stat=1. Then, or after any stat=2 instruction, the state goes RUN to HALTED.
  - In HALTED, dec_ready=0 permanently and cc is frozen. The final result still drains normally.
  - Only resetn returns the state to RUN.

Test Plan:
- Reset, then OPq add (icode 6, ifun 0) with valA=7FFF_FFFF_FFFF_FFFF, valB=1 -> 1 cycle later: ex_valid=1, valE=8000_0000_0000_0000, cc={0,1,1}, dstE=rB.
- OPq sub with valA=5, valB=5, followed by jXX je (icode 7, ifun 3) -> jXX result has cnd=1; cc={1,0,0} after the sub.
- cmovl (icode 2, ifun 2) with cc={0,0,0}, rB=3, valA=9 -> valE=9, cnd=0, dstE=F. Repeat with cc={0,1,0} -> dstE=3.
- pushq with valB=100 and ex_ready held low for 3 cycles -> valE=92 and dstE=4 held stable; dec_ready=0 while the buffer is full; dec_ready=1 in the same cycle ex_ready rises.
- halt, then an OPq presented -> stat=1, ex_valid pulses once, dec_ready stays 0, cc unchanged. Assert resetn low mid-stall -> ex_valid=0 immediately and cc=100.
- icode C, then icode 6 with ifun 5 after reset -> stat=2, dstE=dstM=F, stage HALTED, cc unchanged.

Source files
------------

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, cnd evaluation and dstE
// resolution. The result sits in a single-entry registered output buffer.
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; a producer holding valid keeps its payload stable until that edge.
// A two-state halt machine (state_q) stops intake after halt or an illegal
// instruction. The final result still drains.
module execute_stage #(
    parameter int         DATA_W     = 64,
    parameter int         STACK_STEP = 8,
    parameter logic [2:0] CC_RESET   = 3'b100
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic [DATA_W-1:0] valC,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        ex_icode,
    output logic [DATA_W-1:0] ex_valE,
    output logic [DATA_W-1:0] ex_valA,
    output logic [3:0]        ex_dstE,
    output logic [3:0]        ex_dstM,
    output logic              ex_cnd,
    output logic [2:0]        cc,
    output logic [1:0]        stat
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

    localparam logic [1:0]        STAT_AOK = 2'd0;
    localparam logic [1:0]        STAT_HLT = 2'd1;
    localparam logic [1:0]        STAT_INS = 2'd2;
    localparam logic [3:0]        REG_NONE = 4'hF;
    localparam logic [3:0]        REG_RSP  = 4'h4;
    localparam logic [DATA_W-1:0] STEP     = DATA_W'(STACK_STEP);
    localparam int                MSB      = DATA_W - 1;

    state_t              state_q, state_d;
    logic                ex_valid_q, ex_valid_d;
    logic [3:0]          ex_icode_q, ex_icode_d;
    logic [DATA_W-1:0]   ex_valE_q, ex_valE_d;
    logic [DATA_W-1:0]   ex_valA_q, ex_valA_d;
    logic [3:0]          ex_dstE_q, ex_dstE_d;
    logic [3:0]          ex_dstM_q, ex_dstM_d;
    logic                ex_cnd_q, ex_cnd_d;
    logic [2:0]          cc_q, cc_d;
    logic [1:0]          stat_q, stat_d;

    logic                illegal;
    logic                accept;
    logic [DATA_W-1:0]   sum, diff;
    logic [DATA_W-1:0]   alu_val;
    logic                alu_of;
    logic                cond_eval;
    logic                cnd;
    logic [3:0]          dst_e;
    logic [3:0]          dst_m;
    logic [1:0]          stat_new;

    assign sum       = valB + valA;
    assign diff      = valB - valA;
    assign illegal   = (icode > 4'hB)
                     || (icode == 4'h6 && ifun > 4'h3)
                     || ((icode == 4'h2 || icode == 4'h7) && ifun > 4'h6);
    assign dec_ready = (state_q == ST_RUN) && (!ex_valid_q || ex_ready);
    assign accept    = dec_valid && dec_ready;

    // ALU result and signed-overflow flag for the OPq group
    always_comb begin
        alu_val = '0;
        alu_of  = 1'b0;
        case (icode)
            4'h2: alu_val = valA;
            4'h3: alu_val = valC;
            4'h4, 4'h5: alu_val = valB + valC;
            4'h6: begin
                case (ifun)
                    4'h0: begin
                        alu_val = sum;
                        alu_of  = (valA[MSB] == valB[MSB]) && (sum[MSB] != valB[MSB]);
                    end
                    4'h1: begin
                        alu_val = diff;
                        alu_of  = (valA[MSB] != valB[MSB]) && (diff[MSB] != valB[MSB]);
                    end
                    4'h2: alu_val = valB & valA;
                    4'h3: alu_val = valB ^ valA;
                    default: alu_val = '0;
                endcase
            end
            4'h8, 4'hA: alu_val = valB - STEP;
            4'h9, 4'hB: alu_val = valB + STEP;
            default: alu_val = '0;
        endcase
    end

    // Branch/cmov condition from the registered flags, then dstE/dstM/stat
    always_comb begin
        case (ifun)
            4'h0: cond_eval = 1'b1;
            4'h1: cond_eval = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            4'h2: cond_eval = cc_q[1] ^ cc_q[0];
            4'h3: cond_eval = cc_q[2];
            4'h4: cond_eval = !cc_q[2];
            4'h5: cond_eval = !(cc_q[1] ^ cc_q[0]);
            4'h6: cond_eval = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
            default: cond_eval = 1'b0;
        endcase
        cnd = (icode == 4'h2 || icode == 4'h7) ? cond_eval : 1'b1;

        case (icode)
            4'h2: dst_e = cnd ? rB : REG_NONE;
            4'h3, 4'h6: dst_e = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dst_e = REG_RSP;
            default: dst_e = REG_NONE;
        endcase
        dst_m    = (icode == 4'h5 || icode == 4'hB) ? rA : REG_NONE;
        stat_new = (icode == 4'h0) ? STAT_HLT : STAT_AOK;
        if (illegal) begin
            dst_e    = REG_NONE;
            dst_m    = REG_NONE;
            stat_new = STAT_INS;
        end
    end

    // Next state: buffer load/drain, flag update and halt transition
    always_comb begin
        state_d    = state_q;
        ex_valid_d = ex_valid_q;
        ex_icode_d = ex_icode_q;
        ex_valE_d  = ex_valE_q;
        ex_valA_d  = ex_valA_q;
        ex_dstE_d  = ex_dstE_q;
        ex_dstM_d  = ex_dstM_q;
        ex_cnd_d   = ex_cnd_q;
        cc_d       = cc_q;
        stat_d     = stat_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            ex_icode_d = icode;
            ex_valE_d  = alu_val;
            ex_valA_d  = valA;
            ex_dstE_d  = dst_e;
            ex_dstM_d  = dst_m;
            ex_cnd_d   = cnd;
            stat_d     = stat_new;
            if (icode == 4'h6 && !illegal) begin
                cc_d = {alu_val == '0, alu_val[MSB], alu_of};
            end
            if (stat_new != STAT_AOK) begin
                state_d = ST_HALTED;
            end
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_RUN;
            ex_valid_q <= 1'b0;
            ex_icode_q <= 4'h0;
            ex_valE_q  <= '0;
            ex_valA_q  <= '0;
            ex_dstE_q  <= REG_NONE;
            ex_dstM_q  <= REG_NONE;
            ex_cnd_q   <= 1'b0;
            cc_q       <= CC_RESET;
            stat_q     <= STAT_AOK;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_icode_q <= ex_icode_d;
            ex_valE_q  <= ex_valE_d;
            ex_valA_q  <= ex_valA_d;
            ex_dstE_q  <= ex_dstE_d;
            ex_dstM_q  <= ex_dstM_d;
            ex_cnd_q   <= ex_cnd_d;
            cc_q       <= cc_d;
            stat_q     <= stat_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_icode = ex_icode_q;
    assign ex_valE  = ex_valE_q;
    assign ex_valA  = ex_valA_q;
    assign ex_dstE  = ex_dstE_q;
    assign ex_dstM  = ex_dstM_q;
    assign ex_cnd   = ex_cnd_q;
    assign cc       = cc_q;
    assign stat     = stat_q;

endmodule
